// File: rtl/apb_event_regs.sv
// APB completer holding three saturating event accumulators, sticky overflow status and a write counter.
// Optional feature: define APB_EVT_IRQ_EN to add the IRQ_MASK register (0x14) and the irq_o output.
module apb_event_regs #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        apb_sel_i,
    input  logic        apb_penable_i,
    input  logic [31:0] apb_paddr_i,
    input  logic        apb_pwrite_i,
    input  logic [31:0] apb_pwdata_i,
    output logic        apb_pready_o,
    output logic [31:0] apb_prdata_o,
    output logic        apb_pslverr_o
`ifdef APB_EVT_IRQ_EN
    ,
    output logic        irq_o
`endif
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);
`ifdef APB_EVT_IRQ_EN
    localparam logic [4:0] MAX_OFF = 5'h14;
`else
    localparam logic [4:0] MAX_OFF = 5'h10;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_ERR
    } state_t;

    state_t      state_reg;
    logic [3:0]  wait_cnt_reg;
    logic [31:0] addr_reg;
    logic        write_reg;
    logic [31:0] wdata_reg;
    logic        pready_reg;
    logic        pslverr_reg;
    logic [31:0] prdata_reg;
    logic [31:0] wr_cnt_reg;

    logic [2:0][31:0] evt_val;
    logic [2:0]       status_val;
    logic [2:0]       irq_mask_val;

    logic [4:0]  off;
    logic        acc_err;
    logic        completion;
    logic        wr_commit;
    logic [31:0] rd_val;
    logic [31:0] resp_rdata;
    logic [3:0]  wait_cnt_inc;

    assign off          = addr_reg[4:0];
    assign wait_cnt_inc = wait_cnt_reg + 4'd1;

    // Decode is done on the address latched in SETUP, which stays stable for the whole transfer.
    assign acc_err = (addr_reg[31:5] != BASE_ADDR[31:5]) ||
                     (addr_reg[1:0] != 2'b00) ||
                     (off > MAX_OFF) ||
                     (write_reg && (off == 5'h10));

    assign completion = (state_reg == S_ACCESS) && apb_sel_i && apb_penable_i && pready_reg;
    assign wr_commit  = completion && write_reg && !acc_err;

    always_comb begin
        rd_val = '0;
        case (off)
            5'h00:   rd_val = evt_val[0];
            5'h04:   rd_val = evt_val[1];
            5'h08:   rd_val = evt_val[2];
            5'h0C:   rd_val = {29'd0, status_val};
            5'h10:   rd_val = wr_cnt_reg;
`ifdef APB_EVT_IRQ_EN
            5'h14:   rd_val = {29'd0, irq_mask_val};
`endif
            default: rd_val = '0;
        endcase
    end

    assign resp_rdata = (write_reg || acc_err) ? 32'd0 : rd_val;

    // Response is registered one cycle ahead of PREADY; no other agent can change the
    // registers meanwhile, so prdata still shows the pre-update value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            wdata_reg    <= '0;
            pready_reg   <= 1'b0;
            pslverr_reg  <= 1'b0;
            prdata_reg   <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    pready_reg  <= 1'b0;
                    pslverr_reg <= 1'b0;
                    prdata_reg  <= '0;
                    if (apb_sel_i && !apb_penable_i) begin
                        addr_reg  <= apb_paddr_i;
                        write_reg <= apb_pwrite_i;
                        wdata_reg <= apb_pwdata_i;
                        state_reg <= S_SETUP;
                    end else if (apb_sel_i && apb_penable_i) begin
                        state_reg   <= S_ERR;
                        pready_reg  <= 1'b1;
                        pslverr_reg <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (!apb_sel_i) begin
                        state_reg <= S_IDLE;
                    end else if (apb_penable_i) begin
                        state_reg    <= S_ACCESS;
                        wait_cnt_reg <= '0;
                        if (WS == 4'd0) begin
                            pready_reg  <= 1'b1;
                            pslverr_reg <= acc_err;
                            prdata_reg  <= resp_rdata;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!apb_sel_i || completion) begin
                        state_reg    <= S_IDLE;
                        wait_cnt_reg <= '0;
                        pready_reg   <= 1'b0;
                        pslverr_reg  <= 1'b0;
                        prdata_reg   <= '0;
                    end else if (wait_cnt_reg < WS) begin
                        wait_cnt_reg <= wait_cnt_inc;
                        if (wait_cnt_inc == WS) begin
                            pready_reg  <= 1'b1;
                            pslverr_reg <= acc_err;
                            prdata_reg  <= resp_rdata;
                        end
                    end
                end
                S_ERR: begin
                    state_reg   <= S_IDLE;
                    pready_reg  <= 1'b0;
                    pslverr_reg <= 1'b0;
                    prdata_reg  <= '0;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // One lane per accumulator: 33-bit sum so the carry marks saturation and overflow.
    for (genvar gi = 0; gi < 3; gi++) begin : g_evt
        logic [32:0] sum;
        logic        hit;
        logic [31:0] cnt_reg;
        logic        ovf_reg;

        assign sum = {1'b0, cnt_reg} + {1'b0, wdata_reg};
        assign hit = wr_commit && (off == 5'(gi * 4));

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt_reg <= '0;
            end else if (hit) begin
                cnt_reg <= sum[32] ? 32'hFFFF_FFFF : sum[31:0];
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                ovf_reg <= 1'b0;
            end else if (hit && sum[32]) begin
                ovf_reg <= 1'b1;
            end else if (wr_commit && (off == 5'h0C) && wdata_reg[gi]) begin
                ovf_reg <= 1'b0;
            end
        end

        assign evt_val[gi]    = cnt_reg;
        assign status_val[gi] = ovf_reg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_cnt_reg <= '0;
        end else if (wr_commit) begin
            wr_cnt_reg <= wr_cnt_reg + 32'd1;
        end
    end

`ifdef APB_EVT_IRQ_EN
    logic [2:0] irq_mask_reg;
    logic       irq_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_mask_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_commit && (off == 5'h14)) begin
                irq_mask_reg <= wdata_reg[2:0];
            end
            irq_reg <= |(status_val & irq_mask_reg);
        end
    end

    assign irq_mask_val = irq_mask_reg;
    assign irq_o        = irq_reg;
`else
    assign irq_mask_val = 3'd0;
`endif

    assign apb_pready_o  = pready_reg;
    assign apb_pslverr_o = pslverr_reg;
    assign apb_prdata_o  = prdata_reg;

endmodule

// File: tb/tb_apb_event_regs.sv
// Self-checking bench for apb_event_regs: table-driven transfers with a scoreboard queue,
// plus hand-written sequences for PENABLE errors, reset mid-transfer and aborted waits.
module tb_apb_event_regs;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic        penable = 1'b0;
    logic [31:0] paddr = '0;
    logic        pwrite = 1'b0;
    logic [31:0] pwdata = '0;

    logic        pready0, pslverr0, pready1, pslverr1;
    logic [31:0] prdata0, prdata1;
`ifdef APB_EVT_IRQ_EN
    logic        irq0, irq1;
    localparam int IRQW = 1;
`else
    localparam int IRQW = 0;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    apb_event_regs #(.BASE_ADDR(32'h0), .WAIT_STATES(1)) dut0 (
        .clk(clk), .reset(reset),
        .apb_sel_i(sel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready0), .apb_prdata_o(prdata0), .apb_pslverr_o(pslverr0)
`ifdef APB_EVT_IRQ_EN
        , .irq_o(irq0)
`endif
    );

    apb_event_regs #(.BASE_ADDR(32'h0), .WAIT_STATES(3)) dut1 (
        .clk(clk), .reset(reset),
        .apb_sel_i(sel), .apb_penable_i(penable), .apb_paddr_i(paddr),
        .apb_pwrite_i(pwrite), .apb_pwdata_i(pwdata),
        .apb_pready_o(pready1), .apb_prdata_o(prdata1), .apb_pslverr_o(pslverr1)
`ifdef APB_EVT_IRQ_EN
        , .irq_o(irq1)
`endif
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
        int          waits;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [31:0] a, input logic w, input logic [31:0] d,
                       input logic [31:0] rd, input logic e);
        vec_t v;
        v.addr = a; v.write = w; v.wdata = d; v.exp_rdata = rd; v.exp_err = e;
        vecs.push_back(v);
    endtask

    // Caller is #1 after a rising edge; returns #1 after the completion edge (back-to-back ready).
    task automatic apb_xfer(input int inst, input logic [31:0] a, input logic w,
                            input logic [31:0] d, input logic [31:0] exp_rd,
                            input logic exp_err, input int exp_waits, input string name);
        exp_t e;
        exp_t got_e;
        int   waits;
        bit   got;
        logic rdy, err;
        logic [31:0] rdata;
        e.rdata = exp_rd; e.err = exp_err; e.chk_rd = !w && !exp_err; e.waits = exp_waits;
        exp_q.push_back(e);
        sel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        waits = 0; got = 0; err = 1'b0; rdata = '0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(posedge clk); #1;
            rdy   = (inst == 0) ? pready0 : pready1;
            if (rdy) begin
                got   = 1;
                err   = (inst == 0) ? pslverr0 : pslverr1;
                rdata = (inst == 0) ? prdata0 : prdata1;
            end else begin
                waits++;
            end
        end
        got_e = exp_q.pop_front();
        if (!got) begin
            check({name, " pready_timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " pslverr"}, {31'd0, err}, {31'd0, got_e.err});
            check({name, " waits"}, waits, got_e.waits);
            if (got_e.chk_rd) check({name, " prdata"}, rdata, got_e.rdata);
        end
        $display("xfer %s inst%0d %s addr=%h wdata=%h prdata=%h pslverr=%0b waits=%0d",
                 name, inst, w ? "W" : "R", a, d, rdata, err, waits);
        @(posedge clk); #1;
        sel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset();
        sel = 1'b0; penable = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Main table, instance with one wait state.
        add(32'h00, 1, 32'h0000_0005, 32'h0, 0);
        add(32'h00, 0, 32'h0,         32'h0000_0005, 0);
        add(32'h10, 0, 32'h0,         32'h0000_0001, 0);
        add(32'h04, 1, 32'hFFFF_FFF0, 32'h0, 0);
        add(32'h04, 1, 32'h0000_0020, 32'h0, 0);
        add(32'h04, 0, 32'h0,         32'hFFFF_FFFF, 0);
        add(32'h0C, 0, 32'h0,         32'h0000_0002, 0);
        add(32'h04, 1, 32'h0000_0000, 32'h0, 0);
        add(32'h04, 0, 32'h0,         32'hFFFF_FFFF, 0);
        add(32'h0C, 1, 32'h0000_0002, 32'h0, 0);
        add(32'h0C, 0, 32'h0,         32'h0000_0000, 0);
        add(32'h18, 1, 32'h0000_0001, 32'h0, 1);
        add(32'h10, 1, 32'h0000_0007, 32'h0, 1);
        add(32'h06, 0, 32'h0,         32'h0, 1);
        add(32'h14, 1, 32'h0000_0001, 32'h0, (IRQW == 0));
        add(32'h40, 0, 32'h0,         32'h0, 1);
        add(32'h10, 0, 32'h0,         32'(5 + IRQW), 0);
        add(32'h08, 1, 32'hFFFF_FFFF, 32'h0, 0);
        add(32'h08, 1, 32'h0000_0001, 32'h0, 0);
        add(32'h0C, 0, 32'h0,         32'h0000_0004, 0);
        add(32'h0C, 1, 32'h0000_0003, 32'h0, 0);
        add(32'h0C, 0, 32'h0,         32'h0000_0004, 0);
        add(32'h00, 0, 32'h0,         32'h0000_0005, 0);
        add(32'h08, 0, 32'h0,         32'hFFFF_FFFF, 0);
        add(32'h10, 0, 32'h0,         32'(8 + IRQW), 0);

        repeat (3) @(posedge clk);
        #1;
        check("reset pready0", {31'd0, pready0}, 32'd0);
        check("reset pslverr0", {31'd0, pslverr0}, 32'd0);
        check("reset prdata0", prdata0, 32'd0);
        check("reset pready1", {31'd0, pready1}, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            apb_xfer(0, vecs[i].addr, vecs[i].write, vecs[i].wdata,
                     vecs[i].exp_rdata, vecs[i].exp_err, 1, $sformatf("vec%0d", i));
        end

        // PENABLE without SETUP: one-cycle error response, no state change.
        sel = 1'b1; penable = 1'b1; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h55;
        @(posedge clk); #1;
        check("noset pready", {31'd0, pready0}, 32'd1);
        check("noset pslverr", {31'd0, pslverr0}, 32'd1);
        $display("xfer noset inst0 W addr=00000000 pready=%0b pslverr=%0b", pready0, pslverr0);
        @(posedge clk); #1;
        sel = 1'b0; penable = 1'b0;
        check("noset pready_drop", {31'd0, pready0}, 32'd0);
        @(posedge clk); #1;
        apb_xfer(0, 32'h10, 0, 32'h0, 32'(8 + IRQW), 0, 1, "noset_wrcnt");
        apb_xfer(0, 32'h00, 0, 32'h0, 32'h5, 0, 1, "noset_evta");

        // Reset asserted while a write sits in ACCESS.
        sel = 1'b1; penable = 1'b0; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h77;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        #1;
        check("midrst pready0", {31'd0, pready0}, 32'd0);
        check("midrst pslverr0", {31'd0, pslverr0}, 32'd0);
        check("midrst prdata0", prdata0, 32'd0);
        $display("xfer midrst inst0 W addr=00000000 aborted by reset");
        sel = 1'b0; penable = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        apb_xfer(0, 32'h10, 0, 32'h0, 32'h0, 0, 1, "midrst_wrcnt");
        apb_xfer(0, 32'h00, 0, 32'h0, 32'h0, 0, 1, "midrst_evta");
        apb_xfer(0, 32'h0C, 0, 32'h0, 32'h0, 0, 1, "midrst_status");

        // Three wait states, aborted transfer, then normal completion.
        do_reset();
        apb_xfer(1, 32'h00, 1, 32'h9, 32'h0, 0, 3, "ws3_w9");
        sel = 1'b1; penable = 1'b0; paddr = 32'h00; pwrite = 1'b1; pwdata = 32'h100;
        @(posedge clk); #1 penable = 1'b1;
        @(posedge clk); #1;
        check("abort pready_low", {31'd0, pready1}, 32'd0);
        @(posedge clk); #1;
        sel = 1'b0; penable = 1'b0;
        $display("xfer abort inst1 W addr=00000000 wdata=00000100 dropped sel");
        @(posedge clk); #1;
        check("abort pready_idle", {31'd0, pready1}, 32'd0);
        apb_xfer(1, 32'h00, 0, 32'h0, 32'h9, 0, 3, "abort_evta");
        apb_xfer(1, 32'h10, 0, 32'h0, 32'h1, 0, 3, "abort_wrcnt");
        apb_xfer(1, 32'h00, 1, 32'h1, 32'h0, 0, 3, "ws3_w1");
        apb_xfer(1, 32'h00, 0, 32'h0, 32'hA, 0, 3, "ws3_evta");
        apb_xfer(1, 32'h10, 0, 32'h0, 32'h2, 0, 3, "ws3_wrcnt");

`ifdef APB_EVT_IRQ_EN
        do_reset();
        apb_xfer(0, 32'h14, 1, 32'h1, 32'h0, 0, 1, "irq_mask");
        apb_xfer(0, 32'h14, 0, 32'h0, 32'h1, 0, 1, "irq_mask_rd");
        apb_xfer(0, 32'h00, 1, 32'hFFFF_FFFF, 32'h0, 0, 1, "irq_fill");
        apb_xfer(0, 32'h00, 1, 32'h1, 32'h0, 0, 1, "irq_ovf");
        check("irq_same_cycle", {31'd0, irq0}, 32'd0);
        @(posedge clk); #1;
        check("irq_set", {31'd0, irq0}, 32'd1);
        apb_xfer(0, 32'h0C, 1, 32'h1, 32'h0, 0, 1, "irq_w1c");
        @(posedge clk); #1;
        check("irq_clear", {31'd0, irq0}, 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
